// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per execution unit, round-robin
// grant onto a registered result bus snooped by the ROB and reservation stations.
module cdb_arbiter #(
  parameter int N_REQ     = 3,
  parameter int ROB_WIDTH = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*ROB_WIDTH-1:0]   req_rob_id,
  input  logic [N_REQ*32-1:0]          req_value,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         cdb_valid,
  output logic [ROB_WIDTH-1:0]         cdb_rob_id,
  output logic [31:0]                  cdb_value,
  output logic [N_REQ-1:0]             cdb_src
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [N_REQ-1:0]     buf_valid_q;
  logic [N_REQ-1:0]     buf_valid_d;
  logic [ROB_WIDTH-1:0] buf_rob_id_q [N_REQ];
  logic [31:0]          buf_value_q  [N_REQ];
  logic [N_REQ-1:0]     accept;

  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     rr_ptr_d;

  logic                 cdb_valid_q;
  logic                 cdb_valid_d;
  logic [ROB_WIDTH-1:0] cdb_rob_id_q;
  logic [ROB_WIDTH-1:0] cdb_rob_id_d;
  logic [31:0]          cdb_value_q;
  logic [31:0]          cdb_value_d;
  logic [N_REQ-1:0]     cdb_src_q;
  logic [N_REQ-1:0]     cdb_src_d;

  logic                 active;
  logic [N_REQ-1:0]     grant;
  logic                 grant_any;
  logic [PTR_W-1:0]     grant_idx;

  assign active = rdy_in & ~flush_in;

  // Search buffered entries starting at rr_ptr, wrapping explicitly at N_REQ.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_w;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_w     = '0;
    if (active) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= N_REQ) begin
          idx = idx - N_REQ;
        end
        idx_w = PTR_W'(idx);
        if (!grant_any && buf_valid_q[idx_w]) begin
          grant_any    = 1'b1;
          grant[idx_w] = 1'b1;
          grant_idx    = idx_w;
        end
      end
    end
  end

  // A granted entry frees its slot in the same cycle, so a refill can land
  // on the edge that drains it.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_ready[gi] = rst_in & active & (~buf_valid_q[gi] | grant[gi]);
      assign accept[gi]    = req_valid[gi] & req_ready[gi];

      assign buf_valid_d[gi] = (rdy_in & flush_in) ? 1'b0 :
                               accept[gi]          ? 1'b1 :
                               grant[gi]           ? 1'b0 :
                                                     buf_valid_q[gi];

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          buf_rob_id_q[gi] <= '0;
          buf_value_q[gi]  <= '0;
        end else if (accept[gi]) begin
          buf_rob_id_q[gi] <= req_rob_id[gi*ROB_WIDTH +: ROB_WIDTH];
          buf_value_q[gi]  <= req_value[gi*32 +: 32];
        end
      end
    end
  endgenerate

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_value_d  = cdb_value_q;
    cdb_src_d    = cdb_src_q;
    if (rdy_in) begin
      if (flush_in) begin
        rr_ptr_d    = '0;
        cdb_valid_d = 1'b0;
        cdb_src_d   = '0;
      end else begin
        cdb_valid_d = grant_any;
        cdb_src_d   = grant;
        if (grant_any) begin
          cdb_rob_id_d = buf_rob_id_q[grant_idx];
          cdb_value_d  = buf_value_q[grant_idx];
          rr_ptr_d     = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      buf_valid_q  <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= '0;
    end else begin
      buf_valid_q  <= buf_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_value_q  <= cdb_value_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_rob_id = cdb_rob_id_q;
  assign cdb_value  = cdb_value_q;
  assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: inputs change 1 time unit after posedge,
// outputs are checked on the falling edge against hand-computed values.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic [2:0]  req_valid;
  logic [11:0] req_rob_id;
  logic [95:0] req_value;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value;
  logic [2:0]  cdb_src;

  int n_vec = 0;
  int n_err = 0;

  cdb_arbiter #(.N_REQ(3), .ROB_WIDTH(4)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush_in   (flush_in),
    .req_valid  (req_valid),
    .req_rob_id (req_rob_id),
    .req_value  (req_value),
    .req_ready  (req_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] val_of(input logic [3:0] id);
    return 32'hC0DE_0000 + {28'h0, id};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_in);
  endtask

  task automatic set_req(input logic [2:0] v, input logic [3:0] i0, input logic [3:0] i1,
                         input logic [3:0] i2);
    req_valid  = v;
    req_rob_id = {i2, i1, i0};
    req_value  = {val_of(i2), val_of(i1), val_of(i0)};
  endtask

  task automatic chk_bus(input string tag, input logic v, input logic [3:0] id,
                         input logic [2:0] src);
    chk({tag, ".valid"}, 64'(cdb_valid), 64'(v));
    chk({tag, ".src"}, 64'(cdb_src), 64'(src));
    if (v) begin
      chk({tag, ".id"}, 64'(cdb_rob_id), 64'(id));
      chk({tag, ".value"}, 64'(cdb_value), 64'(val_of(id)));
    end
  endtask

  task automatic single_req(input string tag);
    set_req(3'b001, 4'd5, 4'd0, 4'd0);
    req_value[31:0] = 32'hDEAD_BEEF;
    mid();
    chk({tag, ".ready"}, 64'(req_ready), 64'(3'b111));
    chk({tag, ".idle"}, 64'(cdb_valid), 64'(1'b0));
    tick();
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    mid();
    chk({tag, ".inflight"}, 64'(cdb_valid), 64'(1'b0));
    tick();
    mid();
    chk({tag, ".valid"}, 64'(cdb_valid), 64'(1'b1));
    chk({tag, ".id"}, 64'(cdb_rob_id), 64'(4'd5));
    chk({tag, ".value"}, 64'(cdb_value), 64'(32'hDEAD_BEEF));
    chk({tag, ".src"}, 64'(cdb_src), 64'(3'b001));
    tick();
    mid();
    chk({tag, ".pulse_end"}, 64'(cdb_valid), 64'(1'b0));
    chk({tag, ".src_clr"}, 64'(cdb_src), 64'(3'b000));
    chk({tag, ".id_hold"}, 64'(cdb_rob_id), 64'(4'd5));
    chk({tag, ".value_hold"}, 64'(cdb_value), 64'(32'hDEAD_BEEF));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in   = 1'b0;
    rdy_in   = 1'b1;
    flush_in = 1'b0;
    set_req(3'b111, 4'd1, 4'd2, 4'd3);
    #12;
    chk("rst.valid", 64'(cdb_valid), 64'(1'b0));
    chk("rst.id", 64'(cdb_rob_id), 64'(4'd0));
    chk("rst.value", 64'(cdb_value), 64'(32'd0));
    chk("rst.src", 64'(cdb_src), 64'(3'b000));
    chk("rst.ready", 64'(req_ready), 64'(3'b000));
    tick();
    tick();
    rst_in = 1'b1;
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    tick();

    // Single request; leaves rr_ptr at 1
    single_req("single");

    // Flush with buffers 0 and 2 full and a new request on 1
    set_req(3'b101, 4'd9, 4'd0, 4'd10);
    mid();
    tick();
    set_req(3'b010, 4'd0, 4'd11, 4'd0);
    flush_in = 1'b1;
    mid();
    chk("flush.ready", 64'(req_ready), 64'(3'b000));
    tick();
    flush_in = 1'b0;
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    for (int c = 0; c < 4; c++) begin
      mid();
      chk($sformatf("flush.quiet%0d", c), 64'(cdb_valid), 64'(1'b0));
      tick();
    end

    // Round-robin from rr_ptr=0 (set by the flush)
    set_req(3'b111, 4'd1, 4'd2, 4'd3);
    mid();
    chk("rr.ready", 64'(req_ready), 64'(3'b111));
    tick();
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    mid();
    chk_bus("rr.inflight", 1'b0, 4'd0, 3'b000);
    tick();
    mid(); chk_bus("rr.g0", 1'b1, 4'd1, 3'b001); tick();
    mid(); chk_bus("rr.g1", 1'b1, 4'd2, 3'b010); tick();
    mid(); chk_bus("rr.g2", 1'b1, 4'd3, 3'b100); tick();
    set_req(3'b101, 4'd4, 4'd0, 4'd6);
    mid();
    chk_bus("rr.gap", 1'b0, 4'd0, 3'b000);
    chk("rr.refill_ready", 64'(req_ready), 64'(3'b111));
    tick();
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    mid(); chk_bus("rr.refill_inflight", 1'b0, 4'd0, 3'b000); tick();
    mid(); chk_bus("rr.r0", 1'b1, 4'd4, 3'b001); tick();
    mid(); chk_bus("rr.r2", 1'b1, 4'd6, 3'b100); tick();
    mid(); chk_bus("rr.done", 1'b0, 4'd0, 3'b000); tick();

    // Backpressure on requester 1 (rr_ptr=0)
    set_req(3'b111, 4'd8, 4'd12, 4'd13);
    mid();
    chk("bp.ready_fill", 64'(req_ready), 64'(3'b111));
    tick();
    set_req(3'b010, 4'd0, 4'd14, 4'd0);
    mid();
    chk("bp.ready_wait", 64'(req_ready), 64'(3'b001));
    tick();
    mid();
    chk_bus("bp.g0", 1'b1, 4'd8, 3'b001);
    chk("bp.ready_grant1", 64'(req_ready), 64'(3'b011));
    tick();
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    mid(); chk_bus("bp.g1", 1'b1, 4'd12, 3'b010); tick();
    mid(); chk_bus("bp.g2", 1'b1, 4'd13, 3'b100); tick();
    mid(); chk_bus("bp.g1new", 1'b1, 4'd14, 3'b010); tick();
    mid(); chk_bus("bp.done", 1'b0, 4'd0, 3'b000); tick();

    // Pause while the bus carries id 7 (rr_ptr=2 going in, 1 after)
    set_req(3'b001, 4'd7, 4'd0, 4'd0);
    mid();
    tick();
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    mid();
    tick();
    rdy_in = 1'b0;
    set_req(3'b111, 4'd2, 4'd3, 4'd4);
    for (int p = 0; p < 3; p++) begin
      flush_in = (p == 1);
      mid();
      chk_bus($sformatf("pause%0d", p), 1'b1, 4'd7, 3'b001);
      chk($sformatf("pause%0d.ready", p), 64'(req_ready), 64'(3'b000));
      tick();
    end
    rdy_in   = 1'b1;
    flush_in = 1'b0;
    mid();
    chk("resume.ready", 64'(req_ready), 64'(3'b111));
    chk_bus("resume.hold", 1'b1, 4'd7, 3'b001);
    tick();
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    mid(); chk_bus("resume.gap", 1'b0, 4'd0, 3'b000); tick();
    mid(); chk_bus("resume.g1", 1'b1, 4'd3, 3'b010); tick();
    mid(); chk_bus("resume.g2", 1'b1, 4'd4, 3'b100); tick();
    mid(); chk_bus("resume.g0", 1'b1, 4'd2, 3'b001); tick();
    mid(); chk_bus("resume.done", 1'b0, 4'd0, 3'b000); tick();

    // Asynchronous reset with buffers occupied (rr_ptr=1)
    set_req(3'b111, 4'd1, 4'd2, 4'd3);
    mid();
    tick();
    set_req(3'b000, 4'd0, 4'd0, 4'd0);
    mid();
    tick();
    #2;
    chk_bus("arst.pre", 1'b1, 4'd2, 3'b010);
    set_req(3'b111, 4'd1, 4'd2, 4'd3);
    rst_in = 1'b0;
    #1;
    chk("arst.valid", 64'(cdb_valid), 64'(1'b0));
    chk("arst.id", 64'(cdb_rob_id), 64'(4'd0));
    chk("arst.value", 64'(cdb_value), 64'(32'd0));
    chk("arst.src", 64'(cdb_src), 64'(3'b000));
    chk("arst.ready", 64'(req_ready), 64'(3'b000));
    tick();
    tick();
    rst_in = 1'b1;
    single_req("post_rst");
    mid();
    chk("post_rst.empty", 64'(cdb_valid), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
